vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised successor of the fixed 640x480 test-pattern display path.
- Merges the pixel-clock divider, VGA timing counters and a multi-mode test-pattern source into one block, all running on the system clock with a pixel enable.
- Timing and colour depth are generic. Four runtime-selectable patterns are provided, and mode changes apply glitch-free at frame boundaries.
- Sits directly between the board clock/reset and the VGA connector pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1)
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode_in  in  2  requested pattern
- mode_load  in  1  1-cycle strobe capturing mode_in
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- de  out  1  active-video flag
- pixel_data  out  3*COLOR_W  {R,G,B}, red in the MSBs
- x_pos  out  10  column of the current output pixel
- y_pos  out  10  row of the current output pixel
- frame_start  out  1  1-cycle pulse at the start of each frame
- mode_cur  out  2  pattern currently displayed

Behaviour:
Reset:
- Counters div, h and v are cleared to 0.
- Outputs: h_sync = v_sync = ~SYNC_POL; de = 0; pixel_data = 0; x_pos = y_pos = 0; frame_start = 0; mode_cur = 0; no pending mode.
- Box state: bx = by = 0, dx = dy = +1.
- rst asserted mid-frame restores all of the above on the next edge.

Pixel enable (pe):
- div counts 0..CLK_DIV-1 and wraps.
- pe = 1 when div == CLK_DIV-1. With CLK_DIV = 1, pe is always 1.

Timing counters:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h increments on pe and wraps from H_TOTAL-1 to 0.
- v increments when h wraps and wraps from V_TOTAL-1 to 0.

Output register:
- Updates only on pe edges. Each update captures the decode of (h, v) before the increment, so outputs lag the counters by one pixel period.
- sync_h is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, then driven onto h_sync at SYNC_POL.
- v_sync is decoded the same way from v.
- de = (h < H_ACTIVE) && (v < V_ACTIVE).
- x_pos = h and y_pos = v when de; otherwise they hold their last value.
- pixel_data = 0 whenever de = 0.

frame_start:
- High for exactly one clk cycle: the cycle after the pe edge that captured (h, v) = (0, 0).

Mode handling:
- mode_load latches mode_in into a pending register. A later load before the boundary overwrites it.
- A pending mode moves to mode_cur at the pe edge where (h, v) = (0, 0). The displayed pattern never changes mid-frame.
- mode_load coinciding with that boundary edge becomes pending for the next frame.

Patterns (F = all-ones channel, 0 = zero channel):
- Mode 0, 8 colour bars: BAR_W = H_ACTIVE/8 and index = min(x/BAR_W, 7). Colours in index order: white, yellow (F,F,0), cyan (0,F,F), green, magenta (F,0,F), red, blue, black.
- Mode 1, checkerboard: white when x[5]^y[5], else black.
- Mode 2, grid: white when x[4:0]==0 || y[4:0]==0 || x==H_ACTIVE-1 || y==V_ACTIVE-1, else blue.
- Mode 3, bouncing box: red when bx <= x < bx+32 && by <= y < by+32, else black.

Box update:
- Runs in every mode, once per frame, at the boundary edge.
- If dx = +1 and bx == H_ACTIVE-32: dx becomes -1 and bx decrements.
- If dx = -1 and bx == 0: dx becomes +1 and bx increments.
- Otherwise bx moves by dx.
- by and dy follow the same rule against V_ACTIVE-32.
- Widths are 10 bits. The block requires H_ACTIVE, V_ACTIVE >= 64 and H_TOTAL, V_TOTAL <= 1024.

Test Plan:
- Default params, release reset, mode 0, run 2 frames:
  - h_sync low for 96 pe (384 clk) starting at h = 656; line period 3200 clk.
  - v_sync low for 2 lines starting at line 490; frame_start period 1,680,000 clk.
  - de high 640 pe per line on lines 0..479.
- Mode 0 line scan: x = 0 gives FFF, x = 80 gives FF0, x = 160 gives 0FF, x = 560 gives 000, x = 639 gives 000; pixel_data = 0 at x = 700.
- Mode switch timing: pulse mode_load with mode_in = 1 at line 100. mode_cur stays 0 until the next (0, 0) edge, then becomes 1. At that frame, (32, 0) gives FFF and (0, 0) gives 000.
- Mode 3 bounce, with small params for speed (H_ACTIVE = 64, V_ACTIVE = 64, porches 2/2/2, CLK_DIV = 1):
  - bx is 0, 1, ... 32, 31 over successive frame_starts.
  - Red at (bx, by), black at (bx+32, by).
- Mid-frame reset: assert rst for 1 cycle at h = 300, v = 200. Next cycle: all counters 0, de = 0, h_sync = v_sync = 1, mode_cur = 0, pending mode cleared.
- Mode 2 with CLK_DIV = 1 and SYNC_POL = 1: grid white at (32, 7), (7, 64) and (639, 5); blue at (33, 33); h_sync high during sync.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// VGA timing plus four runtime-selectable test patterns, paced by a pixel enable on the system clock.
// Outputs are registered one pixel period behind the h/v counters; there is no backpressure (free-running raster).
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode_in,
    input  logic                   mode_load,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   de,
    output logic [3*COLOR_W-1:0]   pixel_data,
    output logic [9:0]             x_pos,
    output logic [9:0]             y_pos,
    output logic                   frame_start,
    output logic [1:0]             mode_cur
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  BAR_W  = 10'(H_ACTIVE / 8);
    localparam logic [9:0]  H_EDGE = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_EDGE = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  BX_MAX = 10'(H_ACTIVE - 32);
    localparam logic [9:0]  BY_MAX = 10'(V_ACTIVE - 32);
    localparam logic        SYNC_ON = (SYNC_POL != 0);

    function automatic logic [3*COLOR_W-1:0] rgb(input logic r, input logic g, input logic b);
        return {{COLOR_W{r}}, {COLOR_W{g}}, {COLOR_W{b}}};
    endfunction

    // Returns {direction, position}; direction 1 means moving toward larger coordinates.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic fwd, input logic [9:0] lim);
        logic [10:0] r;
        if (fwd && pos == lim)
            r = {1'b0, pos - 10'd1};
        else if (!fwd && pos == 10'd0)
            r = {1'b1, pos + 10'd1};
        else
            r = {fwd, fwd ? pos + 10'd1 : pos - 10'd1};
        return r;
    endfunction

    logic [DIV_W-1:0]     div_q, div_d;
    logic [9:0]           h_q, h_d, v_q, v_d;
    logic                 h_sync_q, h_sync_d, v_sync_q, v_sync_d, de_q, de_d;
    logic [3*COLOR_W-1:0] pix_q, pix_d;
    logic [9:0]           x_q, x_d, y_q, y_d;
    logic                 fs_q, fs_d;
    logic [1:0]           mode_cur_q, mode_cur_d, pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [9:0]           bx_q, bx_d, by_q, by_d;
    logic                 dx_q, dx_d, dy_q, dy_d;
    logic [9:0]           show_bx_q, show_bx_d, show_by_q, show_by_d;

    logic                 pe, boundary;
    logic [1:0]           mode_eff;
    logic [9:0]           show_bx, show_by;
    logic                 in_hs, in_vs, active, in_box;
    logic [9:0]           bar;
    logic [2:0]           bar_idx;
    logic [3*COLOR_W-1:0] pattern;

    assign pe       = (div_q == DIV_LAST);
    assign boundary = pe && (h_q == 10'd0) && (v_q == 10'd0);
    // The boundary pixel itself already belongs to the new frame, so it sees the new mode and box.
    assign mode_eff = (boundary && pend_vld_q) ? pend_q : mode_cur_q;
    assign show_bx  = boundary ? bx_q : show_bx_q;
    assign show_by  = boundary ? by_q : show_by_q;

    always_comb begin
        in_hs   = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
        in_vs   = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);
        active  = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
        bar     = h_q / BAR_W;
        bar_idx = (bar > 10'd7) ? 3'd7 : bar[2:0];
        in_box  = ({1'b0, h_q} >= {1'b0, show_bx}) && ({1'b0, h_q} < {1'b0, show_bx} + 11'd32) &&
                  ({1'b0, v_q} >= {1'b0, show_by}) && ({1'b0, v_q} < {1'b0, show_by} + 11'd32);
        pattern = '0;
        case (mode_eff)
            2'd0: begin
                case (bar_idx)
                    3'd0:    pattern = rgb(1'b1, 1'b1, 1'b1);
                    3'd1:    pattern = rgb(1'b1, 1'b1, 1'b0);
                    3'd2:    pattern = rgb(1'b0, 1'b1, 1'b1);
                    3'd3:    pattern = rgb(1'b0, 1'b1, 1'b0);
                    3'd4:    pattern = rgb(1'b1, 1'b0, 1'b1);
                    3'd5:    pattern = rgb(1'b1, 1'b0, 1'b0);
                    3'd6:    pattern = rgb(1'b0, 1'b0, 1'b1);
                    default: pattern = rgb(1'b0, 1'b0, 1'b0);
                endcase
            end
            2'd1:    pattern = rgb(h_q[5] ^ v_q[5], h_q[5] ^ v_q[5], h_q[5] ^ v_q[5]);
            2'd2: begin
                if (h_q[4:0] == 5'd0 || v_q[4:0] == 5'd0 || h_q == H_EDGE || v_q == V_EDGE)
                    pattern = rgb(1'b1, 1'b1, 1'b1);
                else
                    pattern = rgb(1'b0, 1'b0, 1'b1);
            end
            default: pattern = rgb(in_box, 1'b0, 1'b0);
        endcase
    end

    always_comb begin
        div_d = pe ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (pe) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        h_sync_d = h_sync_q;
        v_sync_d = v_sync_q;
        de_d     = de_q;
        pix_d    = pix_q;
        x_d      = x_q;
        y_d      = y_q;
        if (pe) begin
            h_sync_d = in_hs ? SYNC_ON : ~SYNC_ON;
            v_sync_d = in_vs ? SYNC_ON : ~SYNC_ON;
            de_d     = active;
            pix_d    = active ? pattern : '0;
            if (active) begin
                x_d = h_q;
                y_d = v_q;
            end
        end
        fs_d = boundary;

        // A load on the boundary edge itself waits for the following frame.
        mode_cur_d = mode_eff;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q && !boundary;
        if (mode_load) begin
            pend_d     = mode_in;
            pend_vld_d = 1'b1;
        end

        show_bx_d  = show_bx;
        show_by_d  = show_by;
        {dx_d, bx_d} = {dx_q, bx_q};
        {dy_d, by_d} = {dy_q, by_q};
        if (boundary) begin
            {dx_d, bx_d} = bounce(bx_q, dx_q, BX_MAX);
            {dy_d, by_d} = bounce(by_q, dy_q, BY_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            h_q        <= 10'd0;
            v_q        <= 10'd0;
            h_sync_q   <= ~SYNC_ON;
            v_sync_q   <= ~SYNC_ON;
            de_q       <= 1'b0;
            pix_q      <= '0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            fs_q       <= 1'b0;
            mode_cur_q <= 2'd0;
            pend_q     <= 2'd0;
            pend_vld_q <= 1'b0;
            bx_q       <= 10'd0;
            by_q       <= 10'd0;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            show_bx_q  <= 10'd0;
            show_by_q  <= 10'd0;
        end else begin
            div_q      <= div_d;
            h_q        <= h_d;
            v_q        <= v_d;
            h_sync_q   <= h_sync_d;
            v_sync_q   <= v_sync_d;
            de_q       <= de_d;
            pix_q      <= pix_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fs_q       <= fs_d;
            mode_cur_q <= mode_cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            show_bx_q  <= show_bx_d;
            show_by_q  <= show_by_d;
        end
    end

    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign de          = de_q;
    assign pixel_data  = pix_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_start = fs_q;
    assign mode_cur    = mode_cur_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised mode loads against a time-indexed raster model; a monitor pops one expected output vector per clock.
module tb_vga_pattern_gen;

    localparam int HA = 64, HFP = 3, HSW = 4, HBP = 5;
    localparam int VA = 64, VFP = 2, VSW = 3, VBP = 2;
    localparam int D  = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME_CLK = HT * VT * D;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] pix;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [1:0]  mode;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_in;
    logic        mode_load;
    logic        h_sync, v_sync, de, frame_start;
    logic [11:0] pixel_data;
    logic [9:0]  x_pos, y_pos;
    logic [1:0]  mode_cur;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(D), .COLOR_W(4), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_load(mode_load),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .pixel_data(pixel_data),
        .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start), .mode_cur(mode_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: clock index since reset release plus the externally visible held values.
    int   m_t, m_mode, m_pend, m_x, m_y;
    bit   m_pend_v, m_hs, m_vs, m_de, m_fs;
    logic [11:0] m_pix;

    function automatic int tri_pos(int f, int m);
        int p = f % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction

    function automatic logic [11:0] exp_pix(int mode, int x, int y, int f);
        int bx, by, idx;
        case (mode)
            0: begin
                idx = x / (HA / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            1: return ((((x / 32) % 2) ^ ((y / 32) % 2)) != 0) ? 12'hFFF : 12'h000;
            2: return (x % 32 == 0 || y % 32 == 0 || x == HA - 1 || y == VA - 1) ? 12'hFFF : 12'h00F;
            default: begin
                bx = tri_pos(f, HA - 32);
                by = tri_pos(f, VA - 32);
                return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 12'hF00 : 12'h000;
            end
        endcase
    endfunction

    task automatic model_step(input logic r, input logic ld, input logic [1:0] md);
        exp_t e;
        int k, h, v, f;
        if (r) begin
            m_t = 0; m_mode = 0; m_pend = 0; m_pend_v = 0;
            m_hs = 1; m_vs = 1; m_de = 0; m_pix = 12'h000; m_x = 0; m_y = 0; m_fs = 0;
        end else begin
            m_fs = 0;
            if (m_t % D == D - 1) begin
                k = m_t / D;
                h = k % HT;
                v = (k / HT) % VT;
                f = k / (HT * VT);
                if (h == 0 && v == 0) begin
                    m_fs = 1;
                    if (m_pend_v) m_mode = m_pend;
                    m_pend_v = 0;
                end
                m_hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
                m_vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
                m_de  = (h < HA) && (v < VA);
                m_pix = m_de ? exp_pix(m_mode, h, v, f) : 12'h000;
                if (m_de) begin
                    m_x = h;
                    m_y = v;
                end
            end
            if (ld) begin
                m_pend   = int'(md);
                m_pend_v = 1;
            end
            m_t++;
        end
        e.hs = m_hs; e.vs = m_vs; e.de = m_de; e.pix = m_pix;
        e.x = 10'(m_x); e.y = 10'(m_y); e.fs = m_fs; e.mode = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({h_sync, v_sync, de, pixel_data, x_pos, y_pos, frame_start, mode_cur} !== e) begin
                    n_fail++;
                    $display("FAIL out@cyc%0d: got hs=%b vs=%b de=%b pix=%h x=%0d y=%0d fs=%b mode=%0d, want hs=%b vs=%b de=%b pix=%h x=%0d y=%0d fs=%b mode=%0d",
                             cyc, h_sync, v_sync, de, pixel_data, x_pos, y_pos, frame_start, mode_cur,
                             e.hs, e.vs, e.de, e.pix, e.x, e.y, e.fs, e.mode);
                end
            end
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: run did not complete within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         done, did_reset, up_pe;
        int         up_k, up_h, up_v, up_f;
        logic [1:0] sched;
        done = 0; did_reset = 0; sched = 2'd3;
        rst = 1'b1; mode_in = 2'd0; mode_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_step(1'b1, 1'b0, 2'd0);
        end
        while (!done) begin
            @(negedge clk);
            rst       = 1'b0;
            mode_load = 1'b0;
            up_pe = (m_t % D) == D - 1;
            up_k  = m_t / D;
            up_h  = up_k % HT;
            up_v  = (up_k / HT) % VT;
            up_f  = up_k / (HT * VT);
            if (up_pe && up_h == 0 && up_v == 10) begin
                mode_load = 1'b1;
                mode_in   = sched;
                sched     = sched + 2'd1;
            end else if (up_pe && up_h == 0 && up_v == 0 && up_f == 2) begin
                mode_load = 1'b1;
                mode_in   = 2'd2;
            end else if ($urandom_range(0, 2999) == 0) begin
                mode_load = 1'b1;
                mode_in   = 2'($urandom_range(0, 3));
            end
            if (!did_reset && up_pe && up_f == 5 && up_h == 40 && up_v == 30) begin
                rst       = 1'b1;
                did_reset = 1;
            end
            model_step(rst, mode_load, mode_in);
            if (did_reset && m_t > 2 * FRAME_CLK + 200) done = 1;
        end
        @(negedge clk);
        mode_load = 1'b0;
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
